shaman_io_bridge: RTL

Parametrised host-side byte interface for the SHA-256 accelerator. It sits between the Tiny Tapeout pins (`ui_in`, `uio_in`, `uio_out`, `uo_out`) and the hash core. It collects a message block byte by byte in either synchronous-parallel or asynchronous-strobe mode, then hands the whole block to the core with a valid/ready handshake. It latches the returned digest and serialises it one byte at a time under host control. It adds several things the first-generation interface lacked: configurable block and digest sizes, input synchronisers, overrun detection, and a wrapping result readout.

---
 rtl/shaman_io_bridge.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/shaman_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : shaman_io_bridge
//  Description : Host-side byte interface for the SHA-256 accelerator.
//                Collects a message block byte by byte (parallel level mode
//                or synchronised strobe mode), hands the block to the hash
//                core with valid/ready, latches the returned digest and
//                serialises it one byte at a time with wrapping readout.
//  Revision    : 1.0 - initial release
// ============================================================================
module shaman_io_bridge #(
   parameter int BLOCK_BYTES  = 64,
   parameter int DIGEST_BYTES = 32,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                data_in,
   input  logic                      clockin_data,
   input  logic                      parallel_loading,
   input  logic                      start,
   input  logic                      result_next,
   output logic [8*BLOCK_BYTES-1:0]  block_data,
   output logic                      block_valid,
   input  logic                      block_ready,
   output logic                      block_start,
   input  logic [8*DIGEST_BYTES-1:0] digest_in,
   input  logic                      digest_valid,
   output logic [7:0]                result_byte,
   output logic                      result_ready,
   output logic                      busy,
   output logic                      block_pending,
   output logic                      overrun
);

   localparam int WW = $clog2(BLOCK_BYTES);
   localparam int RW = (DIGEST_BYTES > 1) ? $clog2(DIGEST_BYTES) : 1;

   typedef enum logic [1:0] {
      S_FILL        = 2'd0,
      S_HANDOFF     = 2'd1,
      S_WAIT_DIGEST = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;

   // Synchroniser chains; bit 0 is the first flop after the pin
   logic [SYNC_STAGES-1:0]   r_sync_strb;
   logic [SYNC_STAGES-1:0]   r_sync_start;
   logic [SYNC_STAGES-1:0]   r_sync_next;
   // Edge detector: [2]=strobe, [1]=start, [0]=result_next
   logic [2:0]               r_prev;
   logic [2:0]               r_edge;
   logic [2:0]               w_sync_out;
   // Data delayed to line up with the registered strobe edge
   logic [SYNC_STAGES:0][7:0] r_dpipe;

   logic [WW-1:0]            r_wr_idx;
   logic [RW-1:0]            r_rd_idx;
   logic [8*BLOCK_BYTES-1:0] r_block;
   logic [8*DIGEST_BYTES-1:0] r_digest;
   logic                     r_result_ready;
   logic                     r_overrun;

   logic                     w_byte_acc;
   logic [7:0]               w_byte;
   logic                     w_start_ev;
   logic                     w_write;
   logic                     w_last;
   logic                     w_overrun_set;
   logic                     w_handoff;
   logic                     w_digest_ev;

   assign w_sync_out = {r_sync_strb[SYNC_STAGES-1],
                        r_sync_start[SYNC_STAGES-1],
                        r_sync_next[SYNC_STAGES-1]};

   // Parallel mode uses the raw level and live data; strobe mode uses the
   // registered edge and the data sampled together with that edge.
   assign w_byte_acc    = parallel_loading ? clockin_data : r_edge[2];
   assign w_byte        = parallel_loading ? data_in : r_dpipe[SYNC_STAGES];
   assign w_start_ev    = r_edge[1] && (r_state == S_FILL);
   assign w_write       = w_byte_acc && (r_state == S_FILL) && !w_start_ev;
   assign w_last        = w_write && (r_wr_idx == WW'(BLOCK_BYTES-1));
   assign w_overrun_set = w_byte_acc && (r_state != S_FILL);
   assign w_handoff     = (r_state == S_HANDOFF) && block_ready;
   assign w_digest_ev   = (r_state == S_WAIT_DIGEST) && digest_valid;

   // Input synchronisers, registered rising-edge detectors and data delay line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync_strb  <= '0;
         r_sync_start <= '0;
         r_sync_next  <= '0;
         r_prev       <= '0;
         r_edge       <= '0;
         r_dpipe      <= '0;
      end else begin
         r_sync_strb  <= {r_sync_strb[SYNC_STAGES-2:0], clockin_data};
         r_sync_start <= {r_sync_start[SYNC_STAGES-2:0], start};
         r_sync_next  <= {r_sync_next[SYNC_STAGES-2:0], result_next};
         r_prev       <= w_sync_out;
         r_edge       <= w_sync_out & ~r_prev;
         r_dpipe      <= {r_dpipe[SYNC_STAGES-1:0], data_in};
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and state-derived handshake/status outputs
   always_comb begin
      w_state_nxt   = r_state;
      block_valid   = 1'b0;
      block_start   = 1'b0;
      busy          = 1'b0;
      block_pending = 1'b0;
      case (r_state)
         S_FILL: begin
            if (w_last) begin
               w_state_nxt = S_HANDOFF;
            end
         end
         S_HANDOFF: begin
            block_valid = 1'b1;
            busy        = 1'b1;
            if (block_ready) begin
               block_start = 1'b1;
               w_state_nxt = S_WAIT_DIGEST;
            end
         end
         S_WAIT_DIGEST: begin
            block_pending = 1'b1;
            busy          = 1'b1;
            if (digest_valid) begin
               w_state_nxt = S_FILL;
            end
         end
         default: begin
            w_state_nxt = S_FILL;
         end
      endcase
   end

   // Write index and block buffer; a start edge wins over a same-cycle byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_idx <= '0;
         r_block  <= '0;
      end else begin
         if (w_start_ev) begin
            r_wr_idx <= '0;
         end else if (w_write) begin
            r_wr_idx <= w_last ? '0 : r_wr_idx + WW'(1);
         end
         if (w_write) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
               if (r_wr_idx == WW'(i)) begin
                  r_block[8*(BLOCK_BYTES-1-i) +: 8] <= w_byte;
               end
            end
         end
      end
   end

   // Digest capture, readout index, result_ready and sticky overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digest       <= '0;
         r_rd_idx       <= '0;
         r_result_ready <= 1'b0;
         r_overrun      <= 1'b0;
      end else begin
         if (w_digest_ev) begin
            r_digest <= digest_in;
         end
         if (w_digest_ev || w_start_ev) begin
            r_rd_idx <= '0;
         end else if (r_edge[0]) begin
            r_rd_idx <= (r_rd_idx == RW'(DIGEST_BYTES-1)) ? '0 : r_rd_idx + RW'(1);
         end
         if (w_digest_ev) begin
            r_result_ready <= 1'b1;
         end else if (w_handoff || w_start_ev) begin
            r_result_ready <= 1'b0;
         end
         if (w_start_ev) begin
            r_overrun <= 1'b0;
         end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
         end
      end
   end

   // Readout mux: digest byte rd_idx, byte 0 in the MSBs
   always_comb begin
      result_byte = 8'h00;
      for (int i = 0; i < DIGEST_BYTES; i++) begin
         if (r_rd_idx == RW'(i)) begin
            result_byte = r_digest[8*(DIGEST_BYTES-1-i) +: 8];
         end
      end
   end

   assign block_data   = r_block;
   assign result_ready = r_result_ready;
   assign overrun      = r_overrun;

endmodule
`default_nettype wire
